instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_if.sv | 32 +++
 rtl/instr_encoder.sv | 165 ++++++++++++++++
 tb/tb_instr_encoder.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Request/response bundle for instr_encoder.
//   Request  : in_valid/in_ready handshake carrying fmt, op, funct, rs, rt,
//              rd, value and pc.
//   Response : out_valid/out_ready handshake carrying instr, err, err_code.
// master drives requests and consumes results; slave is the encoder.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  fmt;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] value;
    logic [31:0] pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        err;
    logic [1:0]  err_code;

    modport master (
        output in_valid, fmt, op, funct, rs, rt, rd, value, pc, out_ready,
        input  in_ready, out_valid, instr, err, err_code
    );

    modport slave (
        input  in_valid, fmt, op, funct, rs, rt, rd, value, pc, out_ready,
        output in_ready, out_valid, instr, err, err_code
    );
endinterface

// File: rtl/instr_encoder.sv
// Compresses a full-width operand into a MIPS-style instruction word.
//   CLK, RST : clock and asynchronous active-low reset.
//   bus      : instr_encoder_if.slave; request accepted in IDLE, encoded in
//              ENC, result held in HOLD until out_ready.
//   NOP_WORD : word emitted whenever the operand does not fit the format.
// All outputs except in_ready come straight from flops.
//
// state | meaning
// IDLE  | ready for a request (in_ready high while out of reset)
// ENC   | captured request is encoded into the result registers
// HOLD  | result presented (out_valid), waiting for out_ready
module instr_encoder #(
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic          CLK,
    input  logic          RST,
    instr_encoder_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ENC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        in_ready;
    logic        accept;
    logic        load_result;

    logic [1:0]  fmt_q;
    logic [5:0]  op_q;
    logic [5:0]  funct_q;
    logic [4:0]  rs_q;
    logic [4:0]  rt_q;
    logic [4:0]  rd_q;
    logic [31:0] value_q;
    logic [31:0] pc_q;

    logic [31:0] instr_q;
    logic        err_q;
    logic [1:0]  err_code_q;

    logic [31:0] enc_word;
    logic [1:0]  enc_code;

    // Only the region bits of pc take part in encoding.
    logic        unused_pc;
    assign unused_pc = ^pc_q[27:0];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        load_result = 1'b0;
        case (state)
            IDLE: begin
                // Gate with RST so in_ready is low for the whole reset.
                in_ready = RST;
                if (bus.in_valid && RST) begin
                    state_nxt = ENC;
                end
            end
            ENC: begin
                load_result = 1'b1;
                state_nxt   = HOLD;
            end
            HOLD: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign accept = bus.in_valid && in_ready;

    // Encoding works only from captured registers, so late input changes
    // cannot leak into the result.
    always_comb begin
        enc_word = NOP_WORD;
        enc_code = 2'b00;
        case (fmt_q)
            2'b00: begin
                if (|value_q[31:5]) begin
                    enc_code = 2'b01;
                end else begin
                    enc_word = {op_q, 5'b0, rt_q, rd_q, value_q[4:0], funct_q};
                end
            end
            2'b01: begin
                if (|value_q[31:16]) begin
                    enc_code = 2'b01;
                end else begin
                    enc_word = {op_q, rs_q, rt_q, value_q[15:0]};
                end
            end
            2'b10: begin
                if (value_q[31:16] != {16{value_q[15]}}) begin
                    enc_code = 2'b01;
                end else begin
                    enc_word = {op_q, rs_q, rt_q, value_q[15:0]};
                end
            end
            default: begin
                // Misalignment is reported ahead of a region mismatch.
                if (|value_q[1:0]) begin
                    enc_code = 2'b10;
                end else if (value_q[31:28] != pc_q[31:28]) begin
                    enc_code = 2'b11;
                end else begin
                    enc_word = {op_q, value_q[27:2]};
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            fmt_q      <= 2'b00;
            op_q       <= 6'd0;
            funct_q    <= 6'd0;
            rs_q       <= 5'd0;
            rt_q       <= 5'd0;
            rd_q       <= 5'd0;
            value_q    <= 32'd0;
            pc_q       <= 32'd0;
            instr_q    <= 32'd0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            if (accept) begin
                fmt_q   <= bus.fmt;
                op_q    <= bus.op;
                funct_q <= bus.funct;
                rs_q    <= bus.rs;
                rt_q    <= bus.rt;
                rd_q    <= bus.rd;
                value_q <= bus.value;
                pc_q    <= bus.pc;
            end
            if (load_result) begin
                instr_q    <= enc_word;
                err_q      <= (enc_code != 2'b00);
                err_code_q <= enc_code;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state == HOLD);
    assign bus.instr     = instr_q;
    assign bus.err       = err_q;
    assign bus.err_code  = err_code_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed vectors with literal
// expectations, backpressure, reset mid-flight, then randomized traffic
// checked every cycle against a behavioural model.
module tb_instr_encoder;
    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
        logic [1:0]  code;
    } res_t;

    logic CLK = 1'b0;
    logic RST;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   or_mode = 0;   // 0: out_ready high, 1: low, 2: random

    instr_encoder_if bus();

    instr_encoder #(.NOP_WORD(NOP)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Rules written as range tests and arithmetic field placement.
    function automatic res_t model(input logic [1:0] f, input logic [5:0] o, input logic [5:0] fu,
                                   input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                                   input logic [31:0] v, input logic [31:0] p);
        res_t  r;
        longint sv;
        r.instr = NOP;
        r.code  = 2'd0;
        sv = longint'($signed(v));
        case (f)
            2'd0: if (v >= 32) r.code = 2'd1;
                  else r.instr = (32'(o) << 26) + (32'(t) << 16) + (32'(d) << 11) + (v << 6) + 32'(fu);
            2'd1: if (v >= 65536) r.code = 2'd1;
                  else r.instr = (32'(o) << 26) + (32'(s) << 21) + (32'(t) << 16) + v;
            2'd2: if (sv < -32768 || sv > 32767) r.code = 2'd1;
                  else r.instr = (32'(o) << 26) + (32'(s) << 21) + (32'(t) << 16) + (v % 65536);
            default: if (v % 4 != 0) r.code = 2'd2;
                  else if ((v >> 28) != (p >> 28)) r.code = 2'd3;
                  else r.instr = (32'(o) << 26) + ((v % 32'h1000_0000) / 4);
        endcase
        r.err = (r.code != 2'd0);
        return r;
    endfunction

    // ---------------- model tracking and per-cycle compare ----------------
    bit          busy = 0;
    bit          was_busy;
    int          ncyc = 0;
    int          acc_cyc = 0;
    res_t        cur;
    logic [1:0]  cur_fmt;
    logic [31:0] cur_val, cur_pc, rtv;

    always @(negedge CLK) begin
        ncyc++;
        if (!RST) begin
            check("rst_in_ready", 32'(bus.in_ready), 32'd0);
            check("rst_out_valid", 32'(bus.out_valid), 32'd0);
            check("rst_instr", bus.instr, 32'd0);
            check("rst_err", {29'd0, bus.err, bus.err_code}, 32'd0);
            busy = 0;
        end else begin
            was_busy = busy;
            check("in_ready", 32'(bus.in_ready), 32'(!busy));
            check("out_valid", 32'(bus.out_valid), 32'(busy && ncyc >= acc_cyc + 2));
            if (busy && ncyc >= acc_cyc + 2) begin
                check("instr", bus.instr, cur.instr);
                check("err", 32'(bus.err), 32'(cur.err));
                check("err_code", 32'(bus.err_code), 32'(cur.code));
                if (ncyc == acc_cyc + 2 && !cur.err) begin
                    case (cur_fmt)
                        2'd0: rtv = {27'd0, bus.instr[10:6]};
                        2'd1: rtv = {16'd0, bus.instr[15:0]};
                        2'd2: rtv = {{16{bus.instr[15]}}, bus.instr[15:0]};
                        default: rtv = {cur_pc[31:28], bus.instr[25:0], 2'b00};
                    endcase
                    check("round_trip", rtv, cur_val);
                end
                if (bus.out_ready) busy = 0;
            end
            if (!was_busy && bus.in_valid) begin
                cur = model(bus.fmt, bus.op, bus.funct, bus.rs, bus.rt, bus.rd, bus.value, bus.pc);
                cur_fmt = bus.fmt;
                cur_val = bus.value;
                cur_pc  = bus.pc;
                acc_cyc = ncyc;
                busy    = 1;
            end
        end
    end

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge CLK);
            #1;
            case (or_mode)
                0: bus.out_ready = 1'b1;
                1: bus.out_ready = 1'b0;
                default: bus.out_ready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // ---------------- drivers ----------------
    task automatic drive(input logic [1:0] f, input logic [5:0] o, input logic [5:0] fu,
                         input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                         input logic [31:0] v, input logic [31:0] p);
        bus.in_valid = 1'b1;
        bus.fmt = f; bus.op = o; bus.funct = fu;
        bus.rs = s; bus.rt = t; bus.rd = d;
        bus.value = v; bus.pc = p;
    endtask

    task automatic wait_ready(output int polls);
        polls = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            polls++;
            if (bus.in_ready) break;
            @(posedge CLK);
            #1;
        end
        if (!bus.in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: in_ready stayed %b, expected 1", bus.in_ready);
        end
        @(posedge CLK);
        #1;
        // Scramble after acceptance: the captured request must not change.
        bus.in_valid = 1'b0;
        bus.fmt = 2'($urandom); bus.op = 6'($urandom); bus.funct = 6'($urandom);
        bus.rs = 5'($urandom); bus.rt = 5'($urandom); bus.rd = 5'($urandom);
        bus.value = $urandom; bus.pc = $urandom;
    endtask

    task automatic send(input logic [1:0] f, input logic [5:0] o, input logic [5:0] fu,
                        input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                        input logic [31:0] v, input logic [31:0] p);
        int polls;
        @(posedge CLK);
        #1;
        drive(f, o, fu, s, t, d, v, p);
        wait_ready(polls);
    endtask

    task automatic wait_out();
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (bus.out_valid) break;
        end
        if (!bus.out_valid) begin
            n_cmp++; n_bad++;
            $display("FAIL out_timeout: out_valid stayed %b, expected 1", bus.out_valid);
        end
    endtask

    task automatic dir(input string nm, input logic [1:0] f, input logic [5:0] o, input logic [5:0] fu,
                       input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                       input logic [31:0] v, input logic [31:0] p,
                       input logic [31:0] ei, input logic ee, input logic [1:0] ec);
        res_t m;
        send(f, o, fu, s, t, d, v, p);
        wait_out();
        check({nm, "_instr"}, bus.instr, ei);
        check({nm, "_err"}, 32'(bus.err), 32'(ee));
        check({nm, "_code"}, 32'(bus.err_code), 32'(ec));
        m = model(f, o, fu, s, t, d, v, p);
        check({nm, "_model"}, {m.instr[29:0], m.code}, {ei[29:0], ec});
    endtask

    task automatic rand_send();
        logic [1:0]  f;
        logic [31:0] v, p;
        logic [15:0] h;
        int          r;
        f = 2'($urandom_range(0, 3));
        r = $urandom_range(0, 3);
        p = $urandom;
        h = 16'($urandom);
        case (f)
            2'd0: v = (r == 0) ? $urandom : $urandom_range(0, 40);
            2'd1: v = (r == 0) ? $urandom : $urandom_range(65500, 65560);
            2'd2: begin
                v = {{16{h[15]}}, h};
                if (r == 0) v = $urandom;
                if (r == 1) v = v ^ 32'h0001_0000;
            end
            default: begin
                v = {p[31:28], 26'($urandom), 2'b00};
                if (r == 0 || r == 2) v[1:0] = 2'($urandom_range(1, 3));
                if (r == 1 || r == 2) v[31:28] = ~p[31:28];
            end
        endcase
        send(f, 6'($urandom), 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), v, p);
    endtask

    task automatic summary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int polls;
        RST = 1'b0;
        bus.in_valid = 1'b0; bus.fmt = 2'd0; bus.op = 6'd0; bus.funct = 6'd0;
        bus.rs = 5'd0; bus.rt = 5'd0; bus.rd = 5'd0; bus.value = 32'd0; bus.pc = 32'd0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(negedge CLK);
        check("ready_after_reset", 32'(bus.in_ready), 32'd1);

        dir("sext_ok",   2'd2, 6'h08, 6'h00, 5'd1, 5'd2, 5'd0, 32'hFFFF_8000, 32'h0, 32'h2022_8000, 1'b0, 2'd0);
        dir("sext_err",  2'd2, 6'h08, 6'h00, 5'd1, 5'd2, 5'd0, 32'h0000_8000, 32'h0, 32'h0000_0000, 1'b1, 2'd1);
        dir("zext_ok",   2'd1, 6'h0D, 6'h00, 5'd3, 5'd4, 5'd0, 32'h0000_FFFF, 32'h0, 32'h3464_FFFF, 1'b0, 2'd0);
        dir("shift_ok",  2'd0, 6'h00, 6'h00, 5'd0, 5'd5, 5'd6, 32'h0000_0004, 32'h0, 32'h0005_3100, 1'b0, 2'd0);
        dir("shift_err", 2'd0, 6'h00, 6'h00, 5'd0, 5'd5, 5'd6, 32'h0000_0020, 32'h0, 32'h0000_0000, 1'b1, 2'd1);
        dir("jump_ok",   2'd3, 6'h02, 6'h00, 5'd7, 5'd0, 5'd0, 32'h0040_0020, 32'h0040_0010, 32'h0810_0008, 1'b0, 2'd0);
        dir("jump_reg",  2'd3, 6'h02, 6'h00, 5'd7, 5'd0, 5'd0, 32'h1000_0000, 32'h0040_0010, 32'h0000_0000, 1'b1, 2'd3);
        dir("jump_mis",  2'd3, 6'h02, 6'h00, 5'd7, 5'd0, 5'd0, 32'h1000_0002, 32'h0040_0010, 32'h0000_0000, 1'b1, 2'd2);

        // Backpressure, then a back-to-back request.
        @(negedge CLK);
        or_mode = 1;
        send(2'd1, 6'h0D, 6'h00, 5'd3, 5'd4, 5'd0, 32'h0000_FFFF, 32'h0);
        wait_out();
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("bp_instr", bus.instr, 32'h3464_FFFF);
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        or_mode = 0;
        @(posedge CLK);
        #1;
        drive(2'd2, 6'h08, 6'h00, 5'd1, 5'd2, 5'd0, 32'hFFFF_8000, 32'h0);
        wait_ready(polls);
        check("b2b_polls", 32'(polls), 32'd2);
        wait_out();
        check("b2b_instr", bus.instr, 32'h2022_8000);

        // Reset while holding a result.
        @(negedge CLK);
        or_mode = 1;
        send(2'd0, 6'h00, 6'h00, 5'd0, 5'd5, 5'd6, 32'h0000_0004, 32'h0);
        wait_out();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        #1;
        check("rst_hold_valid", 32'(bus.out_valid), 32'd0);
        check("rst_hold_instr", bus.instr, 32'd0);
        check("rst_hold_ready", 32'(bus.in_ready), 32'd0);
        @(negedge CLK);
        or_mode = 0;
        @(posedge CLK);
        #1;
        RST = 1'b1;
        @(negedge CLK);
        check("rst_release_ready", 32'(bus.in_ready), 32'd1);
        dir("post_rst", 2'd3, 6'h02, 6'h00, 5'd0, 5'd0, 5'd0, 32'h0040_0020, 32'h0040_0010, 32'h0810_0008, 1'b0, 2'd0);

        // Randomized traffic with random backpressure and gaps.
        @(negedge CLK);
        or_mode = 2;
        for (int k = 0; k < 200; k++) begin
            rand_send();
            repeat ($urandom_range(0, 2)) @(posedge CLK);
        end
        @(negedge CLK);
        or_mode = 0;
        repeat (6) @(posedge CLK);
        summary();
        $finish;
    end

    initial begin
        #1_000_000;
        n_cmp++; n_bad++;
        $display("FAIL watchdog: time limit reached at %0t, expected completion", $time);
        summary();
        $finish;
    end
endmodule
